// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port instruction/data memory between the
//               fetch stage and the load/store stage. Data accesses win by
//               default. A burst limit bounds how many data grants can follow
//               each other while a fetch waits. Drives the fetch freeze and
//               absorbs fetches cancelled by a pc redirect (if_flush).
// Ports       : clk, reset (sync, active-high)
//               fetch : if_req, if_addr, if_flush -> if_rdata, if_valid, freeze
//               data  : d_req, d_we, d_addr, d_wdata -> d_rdata, d_done
//               memory: mem_req, mem_we, mem_addr, mem_wdata <- mem_rdata, mem_ack
// Options     : ARB_STATS_EN adds the stall_cycles and data_grants counters.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 16,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              freeze,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       data_grants
`endif
);

    localparam int                 c_cnt_w     = $clog2(MAX_DATA_BURST + 1);
    localparam logic [c_cnt_w-1:0] c_burst_max = c_cnt_w'(MAX_DATA_BURST);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2,
        IF_DROP = 2'd3   // cancelled fetch still outstanding at the memory
    } state_t;

    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                if_valid_q, if_valid_d;
    logic                d_done_q, d_done_d;
    logic [c_cnt_w-1:0]  burst_q, burst_d;

    // Data wins unless it has used up its burst allowance while fetch waits.
    logic w_grant_d;
    assign w_grant_d = d_req && ((burst_q < c_burst_max) || !if_req);

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        burst_d     = burst_q;
        if_valid_d  = 1'b0;
        d_done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_grant_d) begin
                    state_d     = D_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    if (!if_req)
                        burst_d = '0;
                    else if (burst_q != c_burst_max)
                        burst_d = burst_q + c_cnt_w'(1);
                end else if (if_req && !if_flush) begin
                    state_d    = IF_BUSY;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                    burst_d    = '0;
                end
            end
            IF_BUSY: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    // A flush in the ack cycle swallows the returned word.
                    if (!if_flush) begin
                        if_rdata_d = mem_rdata;
                        if_valid_d = 1'b1;
                    end
                end else if (if_flush) begin
                    state_d = IF_DROP;
                end
            end
            D_BUSY: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    d_done_d  = 1'b1;
                    if (!mem_we_q)
                        d_rdata_d = mem_rdata;
                end
            end
            IF_DROP: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            d_done_q    <= 1'b0;
            burst_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_valid_q  <= if_valid_d;
            d_done_q    <= d_done_d;
            burst_q     <= burst_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_done    = d_done_q;
    assign freeze    = if_req && !if_valid_q;

`ifdef ARB_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] data_grants_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
            data_grants_q  <= '0;
        end else begin
            if (freeze)
                stall_cycles_q <= stall_cycles_q + 32'd1;
            if ((state_q == IDLE) && w_grant_d)
                data_grants_q <= data_grants_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign data_grants  = data_grants_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter. The
//               memory side is driven by hand, step by step; outputs are
//               sampled 1 ns after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_flush, d_req, d_we, mem_ack;
    logic [31:0] if_addr, d_addr;
    logic [15:0] d_wdata, mem_rdata;
    logic [15:0] if_rdata, d_rdata, mem_wdata;
    logic        if_valid, freeze, d_done, mem_req, mem_we;
    logic [31:0] mem_addr;
`ifdef ARB_STATS_EN
    logic [31:0] stall_cycles, data_grants;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_if;
    logic [15:0] exp_d;
    logic        is_d;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (16),
        .MAX_DATA_BURST (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .freeze    (freeze),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef ARB_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .data_grants  (data_grants)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; if_req = 1'b0; if_flush = 1'b0; d_req = 1'b0; d_we = 1'b0;
        mem_ack = 1'b0; if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_mem_req",  {31'd0, mem_req},  32'd0);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_d_done",   {31'd0, d_done},   32'd0);
        chk("rst_mem_addr", mem_addr,          32'd0);
        chk("rst_if_rdata", {16'd0, if_rdata}, 32'd0);
        chk("rst_freeze",   {31'd0, freeze},   32'd0);

        // 1. Plain fetch, ack two cycles after mem_req rises.
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        chk("t1_freeze_idle", {31'd0, freeze}, 32'd1);
        tick();
        chk("t1_mem_req",  {31'd0, mem_req}, 32'd1);
        chk("t1_mem_addr", mem_addr,         32'h10);
        chk("t1_mem_we",   {31'd0, mem_we},  32'd0);
        tick();
        chk("t1_freeze_wait", {31'd0, freeze},   32'd1);
        chk("t1_no_valid",    {31'd0, if_valid}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 16'hA5A5;
        tick();
        mem_ack = 1'b0;
        chk("t1_if_valid", {31'd0, if_valid}, 32'd1);
        chk("t1_if_rdata", {16'd0, if_rdata}, 32'hA5A5);
        chk("t1_freeze_rel", {31'd0, freeze}, 32'd0);
        chk("t1_mem_req_low", {31'd0, mem_req}, 32'd0);
        if_req = 1'b0;
        tick();
        chk("t1_valid_pulse", {31'd0, if_valid}, 32'd0);
        exp_if = 16'hA5A5;

        // 2. Simultaneous load and fetch: data first, then fetch.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        if_req = 1'b1; if_addr = 32'h11;
        tick();
        chk("t2_d_addr", mem_addr,        32'h40);
        chk("t2_d_we",   {31'd0, mem_we}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0; d_req = 1'b0;
        chk("t2_d_done",  {31'd0, d_done},  32'd1);
        chk("t2_d_rdata", {16'd0, d_rdata}, 32'hBEEF);
        chk("t2_freeze",  {31'd0, freeze},  32'd1);
        tick();
        chk("t2_if_addr", mem_addr,         32'h11);
        chk("t2_mem_req", {31'd0, mem_req}, 32'd1);
        chk("t2_d_done_pulse", {31'd0, d_done}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        tick();
        mem_ack = 1'b0; if_req = 1'b0;
        chk("t2_if_rdata", {16'd0, if_rdata}, 32'h1111);
        exp_if = 16'h1111;
        exp_d  = 16'hBEEF;
        tick();

        // 3. Both held: four data grants then one fetch, repeating.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h50;
        if_req = 1'b1; if_addr = 32'h60;
        for (int i = 0; i < 10; i++) begin
            is_d = (i != 4) && (i != 9);
            tick();
            chk($sformatf("t3_addr_%0d", i), mem_addr, is_d ? 32'h50 : 32'h60);
            mem_ack = 1'b1; mem_rdata = 16'h3000 + 16'(i);
            tick();
            mem_ack = 1'b0;
            chk($sformatf("t3_d_done_%0d", i),  {31'd0, d_done},   {31'd0, is_d});
            chk($sformatf("t3_if_valid_%0d", i), {31'd0, if_valid}, {31'd0, !is_d});
            if (i == 9) begin
                d_req = 1'b0; if_req = 1'b0;
            end
        end
        exp_d  = 16'h3008;
        exp_if = 16'h3009;
        chk("t3_d_rdata",  {16'd0, d_rdata},  {16'd0, exp_d});
        chk("t3_if_rdata", {16'd0, if_rdata}, {16'd0, exp_if});
        tick();

        // 4. Flush while the fetch is in flight; the late ack is absorbed.
        if_req = 1'b1; if_addr = 32'h20;
        tick();
        chk("t4_addr_old", mem_addr, 32'h20);
        if_flush = 1'b1;
        tick();
        if_flush = 1'b0; if_addr = 32'h80;
        tick();
        chk("t4_req_held", {31'd0, mem_req}, 32'd1);
        chk("t4_addr_held", mem_addr, 32'h20);
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        mem_ack = 1'b0;
        chk("t4_no_valid",  {31'd0, if_valid}, 32'd0);
        chk("t4_rdata_kept", {16'd0, if_rdata}, {16'd0, exp_if});
        chk("t4_req_low",   {31'd0, mem_req},  32'd0);
        tick();
        chk("t4_addr_new", mem_addr, 32'h80);
        mem_ack = 1'b1; mem_rdata = 16'h8080;
        tick();
        mem_ack = 1'b0;
        chk("t4_valid_new", {31'd0, if_valid}, 32'd1);
        chk("t4_rdata_new", {16'd0, if_rdata}, 32'h8080);
        exp_if = 16'h8080;
        // Fetch re-granted from the pulse cycle, then flushed in its ack cycle.
        if_addr = 32'h22;
        tick();
        chk("t4b_addr", mem_addr, 32'h22);
        mem_ack = 1'b1; mem_rdata = 16'h2222; if_flush = 1'b1; if_req = 1'b0;
        tick();
        mem_ack = 1'b0; if_flush = 1'b0;
        chk("t4b_no_valid",  {31'd0, if_valid}, 32'd0);
        chk("t4b_rdata_kept", {16'd0, if_rdata}, {16'd0, exp_if});
        chk("t4b_req_low",   {31'd0, mem_req},  32'd0);
        // Stray ack while idle is ignored.
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("idle_ack_valid", {31'd0, if_valid}, 32'd0);
        chk("idle_ack_done",  {31'd0, d_done},   32'd0);
        chk("idle_ack_req",   {31'd0, mem_req},  32'd0);

        // 5. Store: write data held until ack, d_rdata untouched.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 16'h1234;
        tick();
        chk("t5_we",    {31'd0, mem_we},     32'd1);
        chk("t5_addr",  mem_addr,            32'h30);
        chk("t5_wdata", {16'd0, mem_wdata},  32'h1234);
        tick();
        chk("t5_we_held",    {31'd0, mem_we},    32'd1);
        chk("t5_wdata_held", {16'd0, mem_wdata}, 32'h1234);
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        tick();
        mem_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
        chk("t5_d_done", {31'd0, d_done},  32'd1);
        chk("t5_d_rdata", {16'd0, d_rdata}, {16'd0, exp_d});
        chk("t5_req_low", {31'd0, mem_req}, 32'd0);
        tick();
        chk("t5_done_pulse", {31'd0, d_done}, 32'd0);
`ifdef ARB_STATS_EN
        chk("stats_grants", data_grants, 32'd10);
`endif

        // 6. Reset in the middle of a load abandons it.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
        tick();
        chk("t6_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1; d_req = 1'b0;
        tick();
        reset = 1'b0;
        chk("t6_req_low", {31'd0, mem_req}, 32'd0);
        chk("t6_no_done", {31'd0, d_done},  32'd0);
        chk("t6_addr_clr", mem_addr,        32'd0);
        tick();
        chk("t6_no_done2",  {31'd0, d_done},   32'd0);
        chk("t6_idle",      {31'd0, mem_req},  32'd0);
        chk("t6_d_rdata",   {16'd0, d_rdata},  32'd0);
        chk("t6_if_rdata",  {16'd0, if_rdata}, 32'd0);
`ifdef ARB_STATS_EN
        chk("t6_stall_clr",  stall_cycles, 32'd0);
        chk("t6_grants_clr", data_grants,  32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
